envelope_detector: RTL and testbench

ENVELOPE_DETECTOR -- requirements
Module: envelope_detector

---
 rtl/envelope_detector_pkg.sv | 17 +
 rtl/envelope_detector_if.sv | 21 ++
 rtl/envelope_detector_abs_sat16.sv | 18 +
 rtl/envelope_detector.sv | 103 ++++++++++
 tb/tb_envelope_detector.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/envelope_detector_pkg.sv
// Shared ADSR constants: phase encodings and detector defaults.
// Common to the envelope generator and the envelope detector.
package envelope_detector_pkg;

  typedef enum logic [1:0] {
    ATTACK  = 2'd0,
    DECAY   = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } phase_t;

  localparam int STEP_DEFAULT   = 480;
  localparam int THRESH_DEFAULT = 64;

  localparam logic [15:0] MAG_MAX = 16'h7fff;

endpackage

// File: rtl/envelope_detector_if.sv
// Sample-in / envelope-out bundle of the envelope detector.
// master drives samples, slave is the detector.
interface envelope_detector_if;

  logic signed [15:0] sample_in;
  logic               in_ready;
  logic        [15:0] envelope_out;
  logic        [1:0]  phase_out;
  logic               env_valid;

  modport master (
    output sample_in, in_ready,
    input  envelope_out, phase_out, env_valid
  );

  modport slave (
    input  sample_in, in_ready,
    output envelope_out, phase_out, env_valid
  );

endinterface

// File: rtl/envelope_detector_abs_sat16.sv
// Combinational 16-bit magnitude; -32768 saturates to 32767.
// Output stays within 0..32767.
module abs_sat16
  import envelope_detector_pkg::*;
(
  input  logic signed [15:0] din,
  output logic        [15:0] mag
);

  always_comb begin
    mag = $unsigned(din);
    if (din == 16'sh8000)
      mag = MAG_MAX;
    else if (din[15])
      mag = $unsigned(-din);
  end

endmodule

// File: rtl/envelope_detector.sv
// Windowed peak envelope follower with ADSR phase classification.
// One result per STEP input strobes, registered with a valid pulse.
module envelope_detector
  import envelope_detector_pkg::*;
#(
  parameter int STEP   = STEP_DEFAULT,
  parameter int THRESH = THRESH_DEFAULT
) (
  input logic          clk,
  input logic          reset,
  envelope_detector_if.slave bus
);

  localparam int CW = (STEP > 1) ? $clog2(STEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP - 1);
  localparam logic signed [16:0] TH = 17'(THRESH);

  logic [CW-1:0] count;
  logic [15:0]   mag;
  logic [15:0]   peak;
  logic [15:0]   prev_peak;
  logic [15:0]   env;
  logic [15:0]   p_close;
  logic [15:0]   env_next;
  logic signed [16:0] delta;
  logic          close;
  logic          rise;
  logic          fall;
  logic          valid;
  phase_t        phase;
  phase_t        phase_next;

  abs_sat16 u_abs (
    .din (bus.sample_in),
    .mag (mag)
  );

  always_comb begin
    close   = bus.in_ready && (count == LAST);
    p_close = (mag > peak) ? mag : peak;
    delta   = $signed({1'b0, p_close})
            - $signed({1'b0, prev_peak});
    rise    = delta > TH;
    fall    = delta < -TH;
    // Decay moves 1/8 of the gap; never crosses below P.
    env_next = (p_close >= env) ? p_close
             : env - ((env - p_close) >> 3);
  end

  always_comb begin
    phase_next = phase;
    if (close) begin
      unique case (phase)
        RELEASE: if (rise) phase_next = ATTACK;
        ATTACK, DECAY: begin
          unique case (1'b1)
            rise:    phase_next = ATTACK;
            fall:    phase_next = DECAY;
            default: phase_next = SUSTAIN;
          endcase
        end
        SUSTAIN: begin
          unique case (1'b1)
            rise:    phase_next = ATTACK;
            fall:    phase_next = RELEASE;
            default: phase_next = SUSTAIN;
          endcase
        end
        default: phase_next = RELEASE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= '0;
      peak      <= '0;
      prev_peak <= '0;
      env       <= '0;
      phase     <= RELEASE;
      valid     <= 1'b0;
    end else begin
      valid <= close;
      phase <= phase_next;
      if (bus.in_ready) begin
        if (close) begin
          count     <= '0;
          peak      <= '0;
          prev_peak <= p_close;
          env       <= env_next;
        end else begin
          count <= count + CW'(1);
          peak  <= p_close;
        end
      end
    end
  end

  assign bus.envelope_out = env;
  assign bus.phase_out    = phase;
  assign bus.env_valid    = valid;

endmodule

// File: tb/tb_envelope_detector.sv
// Randomized and directed bench for envelope_detector.
// Behavioural window model checked every cycle plus literal pins.
module tb_envelope_detector;

  localparam int STEP   = 480;
  localparam int THRESH = 64;
  localparam int NW     = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  envelope_detector_if bus ();

  envelope_detector #(
    .STEP   (STEP),
    .THRESH (THRESH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int m_cnt, m_peak, m_prev, m_env, m_phase, m_valid;
  int n_valid;

  // next phase indexed [phase][0 rise,1 fall,2 flat]
  int nxt [4][3] = '{
    '{0, 1, 2},
    '{0, 1, 2},
    '{0, 3, 2},
    '{0, 3, 3}
  };

  int cap_env [$];
  int cap_ph  [$];
  int data    [NW*STEP];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model(input int s, input bit rdy, input bit rst_n);
    int a, p, d, cls;
    m_valid = 0;
    if (!rst_n) begin
      m_cnt = 0; m_peak = 0; m_prev = 0;
      m_env = 0; m_phase = 3;
      return;
    end
    if (!rdy) return;
    a = (s < 0) ? -s : s;
    if (a > 32767) a = 32767;
    p = (a > m_peak) ? a : m_peak;
    m_cnt++;
    if (m_cnt < STEP) begin
      m_peak = p;
      return;
    end
    d = p - m_prev;
    cls = (d > THRESH) ? 0 : (d < -THRESH) ? 1 : 2;
    m_phase = nxt[m_phase][cls];
    if (p >= m_env) m_env = p;
    else m_env = m_env - (m_env - p) / 8;
    m_prev = p; m_peak = 0; m_cnt = 0;
    m_valid = 1;
  endtask

  task automatic step(input int s, input bit rdy, input bit rst_n);
    @(negedge clk);
    reset = rst_n;
    bus.in_ready = rdy;
    bus.sample_in = 16'(s);
    model(s, rdy, rst_n);
    @(posedge clk);
    #1;
    chk("env_valid", int'(bus.env_valid), m_valid);
    chk("envelope", int'(bus.envelope_out), m_env);
    chk("phase", int'(bus.phase_out), m_phase);
    if (bus.env_valid) begin
      n_valid++;
      cap_env.push_back(int'(bus.envelope_out));
      cap_ph.push_back(int'(bus.phase_out));
    end
  endtask

  task automatic strobes(input int n, input int v);
    for (int i = 0; i < n; i++) step(v, 1'b1, 1'b1);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(20000, 1'b1, 1'b0);
    n_valid = 0;
    cap_env.delete();
    cap_ph.delete();
  endtask

  initial begin
    int ea [$];
    int pa [$];
    bus.in_ready = 1'b0;
    bus.sample_in = '0;
    m_cnt = 0; m_peak = 0; m_prev = 0;
    m_env = 0; m_phase = 3; m_valid = 0;
    n_valid = 0;

    // reset with strobes present, then constant 16384
    do_reset(3);
    chk("rst_env", int'(bus.envelope_out), 0);
    chk("rst_phase", int'(bus.phase_out), 3);
    chk("rst_valid", int'(bus.env_valid), 0);
    strobes(479, 16384);
    chk("no_valid_479", n_valid, 0);
    strobes(1, 16384);
    chk("c16k_env", int'(bus.envelope_out), 16384);
    chk("c16k_phase", int'(bus.phase_out), 0);
    for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b1);
    chk("hold_env", int'(bus.envelope_out), 16384);
    strobes(480, 16384);
    chk("c16k2_env", int'(bus.envelope_out), 16384);
    chk("c16k2_phase", int'(bus.phase_out), 2);
    chk("c16k_pulses", n_valid, 2);

    // full-scale negative then silence
    do_reset(1);
    strobes(480, -32768);
    chk("neg_env", int'(bus.envelope_out), 32767);
    chk("neg_phase", int'(bus.phase_out), 0);
    strobes(480, 0);
    chk("dec_env", int'(bus.envelope_out), 28672);
    chk("dec_phase", int'(bus.phase_out), 1);

    // closing sample is part of the window
    do_reset(1);
    for (int i = 0; i < 479; i++) begin
      step(0, 1'b1, 1'b1);
      if (i % 50 == 0) step(7777, 1'b0, 1'b1);
    end
    chk("no_valid_479b", n_valid, 0);
    strobes(1, 1000);
    chk("last_env", int'(bus.envelope_out), 1000);
    chk("last_pulses", n_valid, 1);

    // identical data, dense vs sparse strobes
    for (int w = 0; w < NW; w++) begin
      int lvl;
      lvl = int'($urandom_range(0, 32767));
      for (int i = 0; i < STEP; i++)
        data[w*STEP+i] = int'($urandom_range(0, 2*lvl)) - lvl;
    end
    do_reset(1);
    for (int i = 0; i < NW*STEP; i++) step(data[i], 1'b1, 1'b1);
    ea = cap_env;
    pa = cap_ph;
    do_reset(1);
    for (int i = 0; i < NW*STEP; i++) begin
      int g;
      g = int'($urandom_range(0, 6));
      for (int k = 0; k < g; k++)
        step(int'($urandom_range(0, 65535)) - 32768, 1'b0, 1'b1);
      step(data[i], 1'b1, 1'b1);
    end
    chk("dense_count", ea.size(), NW);
    chk("sparse_count", cap_env.size(), NW);
    for (int w = 0; w < NW; w++) begin
      if (w < ea.size() && w < cap_env.size()) begin
        chk("seq_env", cap_env[w], ea[w]);
        chk("seq_phase", cap_ph[w], pa[w]);
      end
    end

    // reset discards a partial window
    do_reset(1);
    strobes(300, 20000);
    do_reset(1);
    strobes(479, 100);
    chk("mid_rst_none", n_valid, 0);
    strobes(1, 100);
    chk("mid_rst_env", int'(bus.envelope_out), 100);
    chk("mid_rst_phase", int'(bus.phase_out), 0);
    chk("mid_rst_valid", int'(bus.env_valid), 1);

    // random levels, random strobe density, one random reset
    do_reset(1);
    for (int w = 0; w < 6; w++) begin
      int lvl;
      lvl = int'($urandom_range(0, 32767));
      for (int i = 0; i < 2*STEP; i++) begin
        bit r;
        r = ($urandom_range(0, 9) < 6);
        if (w == 3 && i == 200) step(0, 1'b1, 1'b0);
        else step(int'($urandom_range(0, 2*lvl)) - lvl, r, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
